// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, buffer depth and issue rule for the FIFO stream reader
package fifo_pkg;

  localparam int unsigned D_WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned BUF_DEPTH   = 2;

  typedef logic [1:0] occ_t;

  // Words already owned by the buffer (stored or in flight) after this cycle's pop.
  function automatic logic can_issue(input occ_t occ, input logic inflight, input logic pop);
    logic [2:0] pending;
    pending = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    return pending < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - two-entry ring buffer absorbing the FIFO's one-cycle read latency
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               rd,
  output logic [D_WIDTH-1:0] rdata,
  output occ_t               occ
);

  logic [D_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  occ_t               occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ wr;
    rd_ptr_d = rd_ptr_q ^ rd;
    occ_d    = occ_q;
    case ({wr, rd})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is left unreset; occupancy alone decides whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - turns a synchronous FIFO read port into a valid/ready stream
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned D_WIDTH = D_WIDTH_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               fifo_empty,
  input  logic [D_WIDTH-1:0] fifo_rdata,
  output logic               fifo_r_en,
  output logic               m_valid,
  output logic [D_WIDTH-1:0] m_data,
  input  logic               m_ready,
  output logic [CNT_W-1:0]   word_cnt
);

  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             pop;
  occ_t             occ;

  skid_buf2 #(
    .D_WIDTH(D_WIDTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .wr   (inflight_q),
    .wdata(fifo_rdata),
    .rd   (pop),
    .rdata(m_data),
    .occ  (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  // A read is only issued when its word is guaranteed a slot on arrival.
  assign fifo_r_en = !rst & en & !fifo_empty & can_issue(occ, inflight_q, pop);

  always_comb begin
    inflight_d = fifo_r_en;
    word_cnt_d = word_cnt_q;
    if (pop) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed and random checks of fifo_stream_reader against a FIFO model
module tb_fifo_stream_reader;

  localparam int MASK     = 65535;
  localparam int WRAP_PRE = 65533;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_r_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [15:0] word_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_count = 0;
  int   rd_count = 0;
  int   exp_idx  = 0;
  bit   mon_en   = 1'b0;
  logic [7:0] mem [0:65535];

  logic       hold_q;
  logic [7:0] hold_data;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .D_WIDTH(8),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_r_en (fifo_r_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .word_cnt  (word_cnt)
  );

  assign fifo_empty = (wr_count == rd_count);

  // Synchronous FIFO model: one-cycle read latency, flushed by reset.
  always @(posedge clk) begin
    if (rst) begin
      rd_count <= wr_count;
    end else if (fifo_r_en) begin
      fifo_rdata <= mem[rd_count & MASK];
      rd_count   <= rd_count + 1;
    end
  end

  // Stream monitor: ordering scoreboard, hold stability, no capture into a full buffer.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        n_checks++;
        if (!m_valid || m_data !== hold_data) begin
          n_fail++;
          $display("FAIL hold_stable: m_valid=%0b m_data=%h required m_valid=1 m_data=%h", m_valid, m_data, hold_data);
        end
      end
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== mem[exp_idx & MASK]) begin
          n_fail++;
          $display("FAIL order idx=%0d: m_data=%h required %h", exp_idx, m_data, mem[exp_idx & MASK]);
        end
        exp_idx++;
      end
      n_checks++;
      if (dut.inflight_q && dut.u_buf.occ == 2'd2 && !(m_valid && m_ready)) begin
        n_fail++;
        $display("FAIL overflow: capture with occ=%0d and no pop, required no capture", dut.u_buf.occ);
      end
      hold_q    = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_count & MASK] = d;
    wr_count++;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_idx == wr_count) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; m_ready = 1'b1;
    push(8'h5A);
    tick();
    push(8'h5B);
    @(negedge clk);
    n_checks++;
    if (fifo_r_en !== 1'b0) begin n_fail++; $display("FAIL reset_ren: fifo_r_en=%0b required 0", fifo_r_en); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: m_valid=%0b required 0", m_valid); end
    n_checks++;
    if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: word_cnt=%0d required 0", word_cnt); end
    tick();
    rst = 1'b0;
    exp_idx = wr_count;
    mon_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || fifo_r_en !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: m_valid=%0b fifo_r_en=%0b required 0 0", m_valid, fifo_r_en);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [5:0] exp_ren = 6'b000111;
    logic [5:0] exp_vld = 6'b011100;
    tick();
    push(8'h11); push(8'h22); push(8'h33);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_r_en !== exp_ren[c]) begin n_fail++; $display("FAIL basic_ren c=%0d: fifo_r_en=%0b required %0b", c, fifo_r_en, exp_ren[c]); end
      n_checks++;
      if (m_valid !== exp_vld[c]) begin n_fail++; $display("FAIL basic_valid c=%0d: m_valid=%0b required %0b", c, m_valid, exp_vld[c]); end
      if (exp_vld[c]) begin
        n_checks++;
        if (m_data !== 8'h11 * 8'(c - 1)) begin n_fail++; $display("FAIL basic_data c=%0d: m_data=%h required %h", c, m_data, 8'h11 * 8'(c - 1)); end
      end
      if (c == 5) begin
        n_checks++;
        if (word_cnt !== 16'd3) begin n_fail++; $display("FAIL basic_cnt: word_cnt=%0d required 3", word_cnt); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int reads = 0;
    tick();
    m_ready = 1'b0;
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (fifo_r_en) reads++;
      if (c == 5) begin
        n_checks++;
        if (dut.u_buf.occ !== 2'd2) begin n_fail++; $display("FAIL stall_occ: occ=%0d required 2", dut.u_buf.occ); end
        n_checks++;
        if (fifo_r_en !== 1'b0) begin n_fail++; $display("FAIL stall_ren: fifo_r_en=%0b required 0", fifo_r_en); end
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA0) begin n_fail++; $display("FAIL stall_head: m_valid=%0b m_data=%h required 1 a0", m_valid, m_data); end
      end
      tick();
    end
    n_checks++;
    if (reads != 2) begin n_fail++; $display("FAIL stall_reads: reads=%0d required 2", reads); end
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (c < 4 && (m_valid !== 1'b1 || m_data !== 8'hA0 + 8'(c))) begin
        n_fail++;
        $display("FAIL stall_release c=%0d: m_valid=%0b m_data=%h required 1 %h", c, m_valid, m_data, 8'hA0 + 8'(c));
      end else if (c == 4 && (m_valid !== 1'b0 || word_cnt !== 16'd7)) begin
        n_fail++;
        $display("FAIL stall_done: m_valid=%0b word_cnt=%0d required 0 7", m_valid, word_cnt);
      end
      tick();
    end
  endtask

  task automatic test_en_gap();
    bit ok;
    tick();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
    for (int c = 0; c < 5; c++) begin
      if (c == 2) en = 1'b0;
      @(negedge clk);
      n_checks++;
      if (fifo_r_en !== (c < 2)) begin n_fail++; $display("FAIL gap_ren c=%0d: fifo_r_en=%0b required %0b", c, fifo_r_en, c < 2); end
      if (c == 2 || c == 3) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hC0 + 8'(c - 2)) begin
          n_fail++;
          $display("FAIL gap_inflight c=%0d: m_valid=%0b m_data=%h required 1 %h", c, m_valid, m_data, 8'hC0 + 8'(c - 2));
        end
      end
      if (c == 4) begin
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL gap_empty: m_valid=%0b required 0", m_valid); end
      end
      tick();
    end
    en = 1'b1;
    drain(40, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL gap_drain: delivered=%0d required %0d", exp_idx, wr_count); end
    n_checks++;
    if (word_cnt !== 16'd15) begin n_fail++; $display("FAIL gap_cnt: word_cnt=%0d required 15", word_cnt); end
  endtask

  task automatic test_random();
    int pushed = 0;
    int start  = exp_idx;
    bit ok;
    for (int cyc = 0; cyc < 40000 && (exp_idx - start) < 10000; cyc++) begin
      en      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 4) != 0);
      if (pushed < 10000 && $urandom_range(0, 9) < 7) begin
        push(8'($urandom));
        pushed++;
      end
      tick();
    end
    en = 1'b1; m_ready = 1'b1;
    drain(20, ok);
    n_checks++;
    if (exp_idx - start != 10000) begin n_fail++; $display("FAIL random_count: delivered=%0d required 10000", exp_idx - start); end
    n_checks++;
    if (word_cnt !== 16'd10015) begin n_fail++; $display("FAIL random_cnt: word_cnt=%0d required 10015", word_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    tick();
    en = 1'b1; m_ready = 1'b0;
    push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
    tick();
    tick();
    n_checks++;
    if (dut.u_buf.occ !== 2'd1 || dut.inflight_q !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: occ=%0d inflight=%0b required 1 1", dut.u_buf.occ, dut.inflight_q);
    end
    rst = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_r_en !== 1'b0) begin n_fail++; $display("FAIL mid_ren_forced: fifo_r_en=%0b required 0", fifo_r_en); end
    tick();
    n_checks++;
    if (m_valid !== 1'b0 || word_cnt !== 16'd0 || fifo_r_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after: m_valid=%0b word_cnt=%0d fifo_r_en=%0b required 0 0 0", m_valid, word_cnt, fifo_r_en);
    end
    rst = 1'b0;
    m_ready = 1'b1;
    exp_idx = wr_count;
    mon_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale c=%0d: m_valid=%0b m_data=%h required 0", c, m_valid, m_data); end
      tick();
    end
    push(8'hE0); push(8'hE1);
    drain(20, ok);
    n_checks++;
    if (!ok || word_cnt !== 16'd2) begin n_fail++; $display("FAIL mid_resume: word_cnt=%0d required 2", word_cnt); end
  endtask

  task automatic test_wrap();
    bit ok;
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < WRAP_PRE; i++) begin
      push(8'(i));
      tick();
    end
    drain(40, ok);
    n_checks++;
    if (!ok || word_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max: word_cnt=%0d required 65535", word_cnt); end
    push(8'h77);
    drain(20, ok);
    n_checks++;
    if (!ok || word_cnt !== 16'd0) begin n_fail++; $display("FAIL wrap_zero: word_cnt=%0d required 0", word_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_en_gap();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
